// File: rtl/pattern_stream_gen.sv
// pattern_stream_gen
//   Transmit-side companion of the serial pattern detector. Accepts 2-bit
//   detection codes over a valid/ready handshake, buffers them in a small
//   FIFO and serializes each one into the bit sequence that makes the
//   detector fire. Alongside every emitted bit it presents the detector
//   output that bit must produce, so a bench compares directly.
//
//   Codes: 10 -> bits 1,1,0   01 -> bits 0,0,1   00 -> one filler bit
//          11 -> invalid: accepted, flagged in err_invalid, never queued.
//
// Ports
//   clock        single clock, all state changes on posedge
//   reset        synchronous active-high reset
//   cmd_valid    command present on cmd
//   cmd[1:0]     detection code {o0,o1}
//   cmd_ready    FIFO not full (combinational from FIFO count)
//   bit_out      serial bit, registered (IDLE_BIT when not valid)
//   bit_valid    bit_out carries a stream bit this cycle
//   expect_o     detector output required for this bit, registered
//   busy         FIFO non-empty or a pattern still has bits to show
//   err_invalid  sticky: a code 11 was accepted since reset
module pattern_stream_gen #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic        IDLE_BIT   = 1'b0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       cmd_valid,
  input  logic [1:0] cmd,
  output logic       cmd_ready,
  output logic       bit_out,
  output logic       bit_valid,
  output logic [1:0] expect_o,
  output logic       busy,
  output logic       err_invalid
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic {
    S_IDLE,
    S_SHIFT
  } state_t;

  // Bits of a code, MSB emitted first. A filler only uses the MSB.
  function automatic logic [2:0] pat_bits(input logic [1:0] code);
    case (code)
      2'b10:   pat_bits = 3'b110;
      2'b01:   pat_bits = 3'b001;
      default: pat_bits = {IDLE_BIT, 2'b00};
    endcase
  endfunction

  function automatic logic [1:0] pat_len(input logic [1:0] code);
    pat_len = (code == 2'b00) ? 2'd1 : 2'd3;
  endfunction

  // Detector model: hist = {h1,h2}, h1 being the most recent bit.
  function automatic logic [1:0] det_out(input logic [1:0] hist, input logic b);
    if (hist == 2'b11 && !b)      det_out = 2'b10;
    else if (hist == 2'b00 && b)  det_out = 2'b01;
    else                          det_out = 2'b00;
  endfunction

  // Command FIFO storage
  logic [1:0] mem [FIFO_DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Serializer: shreg_q holds bits not yet presented (MSB next),
  // left_q counts them. SHIFT exactly when left_q != 0.
  state_t     state_q, state_d;
  logic [2:0] shreg_q, shreg_d;
  logic [1:0] left_q, left_d;

  logic       bit_out_q, bit_out_d;
  logic       bit_valid_q, bit_valid_d;
  logic [1:0] expect_q, expect_d;
  logic [1:0] hist_q, hist_d;
  logic       err_q, err_d;

  logic       fifo_full;
  logic       fifo_empty;
  logic       accept;
  logic       push;
  logic       pop;
  logic       emit;
  logic       emit_bit;
  logic [1:0] head;
  logic [2:0] head_bits;
  logic [1:0] head_len;

  assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign head       = mem[rd_ptr_q];
  assign head_bits  = pat_bits(head);
  assign head_len   = pat_len(head);

  assign cmd_ready  = !fifo_full;
  assign accept     = cmd_valid && cmd_ready;
  assign push       = accept && (cmd != 2'b11);

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    left_d      = left_q;
    pop         = 1'b0;
    emit        = 1'b0;
    emit_bit    = IDLE_BIT;

    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          // Pop and present the first bit in the same edge.
          pop      = 1'b1;
          emit     = 1'b1;
          emit_bit = head_bits[2];
          shreg_d  = {head_bits[1:0], 1'b0};
          left_d   = head_len - 2'd1;
          state_d  = (head_len > 2'd1) ? S_SHIFT : S_IDLE;
        end
      end
      S_SHIFT: begin
        emit     = 1'b1;
        emit_bit = shreg_q[2];
        shreg_d  = {shreg_q[1:0], 1'b0};
        left_d   = left_q - 2'd1;
        if (left_q == 2'd1) begin
          // Last bit of this pattern goes out now; stage the next command
          // so its first bit follows on the next edge without a gap.
          if (!fifo_empty) begin
            pop     = 1'b1;
            shreg_d = head_bits;
            left_d  = head_len;
            state_d = S_SHIFT;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    bit_valid_d = emit;
    bit_out_d   = emit ? emit_bit : IDLE_BIT;
    expect_d    = emit ? det_out(hist_q, emit_bit) : 2'b00;
    hist_d      = emit ? {emit_bit, hist_q[1]} : hist_q;

    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    err_d = err_q || (accept && (cmd == 2'b11));
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr_q] <= cmd;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      state_q     <= S_IDLE;
      shreg_q     <= '0;
      left_q      <= '0;
      bit_out_q   <= IDLE_BIT;
      bit_valid_q <= 1'b0;
      expect_q    <= 2'b00;
      hist_q      <= 2'b10;
      err_q       <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      left_q      <= left_d;
      bit_out_q   <= bit_out_d;
      bit_valid_q <= bit_valid_d;
      expect_q    <= expect_d;
      hist_q      <= hist_d;
      err_q       <= err_d;
    end
  end

  assign bit_out     = bit_out_q;
  assign bit_valid   = bit_valid_q;
  assign expect_o    = expect_q;
  assign err_invalid = err_q;
  // A bit still on bit_out counts as work in progress.
  assign busy        = (count_q != '0) || (left_q != 2'd0) || bit_valid_q;

endmodule

// File: tb/tb_pattern_stream_gen.sv
// Directed bench for pattern_stream_gen: drives codes through the handshake
// and compares the serial stream, expect_o and status flags against
// hand-derived sequences. Inputs change 1 time unit after posedge; outputs
// are sampled at that same point, well away from the next edge.
module tb_pattern_stream_gen;

  logic       clock;
  logic       reset;
  logic       cmd_valid;
  logic [1:0] cmd;
  logic       cmd_ready;
  logic       bit_out;
  logic       bit_valid;
  logic [1:0] expect_o;
  logic       busy;
  logic       err_invalid;

  int n_tests = 0;
  int n_fail  = 0;

  pattern_stream_gen #(
    .FIFO_DEPTH(4),
    .IDLE_BIT  (1'b0)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd        (cmd),
    .cmd_ready  (cmd_ready),
    .bit_out    (bit_out),
    .bit_valid  (bit_valid),
    .expect_o   (expect_o),
    .busy       (busy),
    .err_invalid(err_invalid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd       = 2'b00;
    step();
    reset = 1'b0;
  endtask

  // Compare the bit currently presented against one expected stream entry.
  task automatic check_bit(input string tag, input int idx, input logic b, input logic [1:0] e);
    $display("[TB] %s bit %0d: valid=%0b bit_out=%0b expect_o=%b (want %0b/%b)",
             tag, idx, bit_valid, bit_out, expect_o, b, e);
    check($sformatf("%s_valid%0d", tag, idx), 32'(bit_valid), 32'(1'b1));
    check($sformatf("%s_bit%0d", tag, idx), 32'(bit_out), 32'(b));
    check($sformatf("%s_exp%0d", tag, idx), 32'(expect_o), 32'(e));
    check($sformatf("%s_busy%0d", tag, idx), 32'(busy), 32'(1'b1));
  endtask

  // bits/exps are written MSB-first: leftmost entry is the first bit.
  task automatic check_stream(input string tag, input int n,
                              input logic [15:0] bits, input logic [31:0] exps);
    for (int i = 0; i < n; i++) begin
      check_bit(tag, i, bits[n-1-i], exps[2*(n-1-i) +: 2]);
      step();
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_valid"}, 32'(bit_valid), 32'(1'b0));
    check({tag, "_bit"}, 32'(bit_out), 32'(1'b0));
    check({tag, "_exp"}, 32'(expect_o), 32'(2'b00));
    check({tag, "_busy"}, 32'(busy), 32'(1'b0));
  endtask

  initial begin
    int accepted;
    logic [10:0] fill_bits;
    logic [21:0] fill_exps;

    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd       = 2'b00;

    // Reset state
    do_reset();
    check_idle("rst");
    check("rst_ready", 32'(cmd_ready), 32'(1'b1));
    check("rst_err", 32'(err_invalid), 32'(1'b0));

    // Single code 10: accepted at edge 1, bits after edges 2..4
    cmd_valid = 1'b1; cmd = 2'b10;
    step();
    cmd_valid = 1'b0;
    check("p110_lat_valid", 32'(bit_valid), 32'(1'b0));
    check("p110_lat_busy", 32'(busy), 32'(1'b1));
    step();
    check_stream("p110", 3, 16'(3'b110), 32'(6'b00_00_10));
    check_idle("p110_end");

    // Single code 01 from fresh history
    do_reset();
    cmd_valid = 1'b1; cmd = 2'b01;
    step();
    cmd_valid = 1'b0;
    step();
    check_stream("p001", 3, 16'(3'b001), 32'(6'b00_00_01));
    check_idle("p001_end");

    // 10 then 01 back to back: six contiguous bits, overlap fires on bit 6
    do_reset();
    cmd_valid = 1'b1; cmd = 2'b10;
    step();
    cmd = 2'b01;
    step();
    cmd_valid = 1'b0;
    check_stream("pair", 6, 16'(6'b110001), 32'(12'b00_00_10_00_00_01));
    check_idle("pair_end");

    // FIFO fill: two 10s keep the serializer occupied while five fillers
    // are offered continuously; with depth 4 the 5th must wait a cycle.
    do_reset();
    cmd_valid = 1'b1; cmd = 2'b10;
    step();
    step();
    cmd = 2'b00;
    accepted  = 0;
    fill_bits = 11'b110_110_00000;
    fill_exps = 22'b00_00_10_00_00_10_00_00_00_00_00;
    for (int k = 0; k < 11; k++) begin
      check_bit("fill", k, fill_bits[10-k], fill_exps[2*(10-k) +: 2]);
      if (k == 4) check("fill_ready_full", 32'(cmd_ready), 32'(1'b0));
      if (k == 5) check("fill_ready_back", 32'(cmd_ready), 32'(1'b1));
      if (cmd_valid && cmd_ready) accepted++;
      step();
      if (accepted == 5) cmd_valid = 1'b0;
    end
    check("fill_accepted", 32'(accepted), 32'd5);
    check_idle("fill_end");

    // Invalid code 11: flagged, not queued, sticky across later traffic
    do_reset();
    cmd_valid = 1'b1; cmd = 2'b11;
    check("inv_ready", 32'(cmd_ready), 32'(1'b1));
    step();
    cmd_valid = 1'b0;
    check("inv_err", 32'(err_invalid), 32'(1'b1));
    check_idle("inv_t1");
    step();
    check_idle("inv_t2");
    cmd_valid = 1'b1; cmd = 2'b10;
    step();
    cmd_valid = 1'b0;
    step();
    check_bit("inv_p", 0, 1'b1, 2'b00);
    step();
    check_bit("inv_p", 1, 1'b1, 2'b00);
    check("inv_err_held", 32'(err_invalid), 32'(1'b1));

    // Reset after the 2nd bit of 110: everything discarded, history back to 10
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_idle("mid_rst");
    check("mid_rst_ready", 32'(cmd_ready), 32'(1'b1));
    check("mid_rst_err", 32'(err_invalid), 32'(1'b0));
    step();
    check_idle("mid_rst_t2");
    cmd_valid = 1'b1; cmd = 2'b01;
    step();
    cmd_valid = 1'b0;
    step();
    check_stream("post_rst", 3, 16'(3'b001), 32'(6'b00_00_01));
    check_idle("post_rst_end");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
